// File: rtl/ark_pkg.sv
// Shared types and elaboration helpers for the AddRoundKey engine.
// Holds the FSM encoding, mode constants and the ROWS legality check.
package ark_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } ark_state_e;

    localparam logic [1:0] ARK_XOR  = 2'd0;
    localparam logic [1:0] ARK_COPY = 2'd1;
    localparam logic [1:0] ARK_LOAD = 2'd2;

    function automatic bit rows_ok(input int rows);
        return (rows >= 4) && (rows % 2 == 0);
    endfunction

endpackage

// File: rtl/add_round_key_nb_if.sv
// Control handshake plus statemt/word dual-port RAM bus.
// master = engine side, slave = controller/RAM side.
interface add_round_key_nb_if #(
    parameter int DW       = 32,
    parameter int STATE_AW = 5,
    parameter int WORD_AW  = 9
) ();
    logic                ap_start;
    logic                ap_continue;
    logic                ap_done;
    logic                ap_idle;
    logic                ap_ready;
    logic [4:0]          n;
    logic [1:0]          mode;
    logic [STATE_AW-1:0] statemt_address0;
    logic [STATE_AW-1:0] statemt_address1;
    logic                statemt_ce0;
    logic                statemt_ce1;
    logic                statemt_we0;
    logic                statemt_we1;
    logic [DW-1:0]       statemt_d0;
    logic [DW-1:0]       statemt_d1;
    logic [DW-1:0]       statemt_q0;
    logic [DW-1:0]       statemt_q1;
    logic [WORD_AW-1:0]  word_address0;
    logic [WORD_AW-1:0]  word_address1;
    logic                word_ce0;
    logic                word_ce1;
    logic [DW-1:0]       word_q0;
    logic [DW-1:0]       word_q1;
    logic [DW-1:0]       chk;

    modport master (
        input  ap_start, ap_continue, n, mode,
        input  statemt_q0, statemt_q1, word_q0, word_q1,
        output ap_done, ap_idle, ap_ready, chk,
        output statemt_address0, statemt_address1,
        output statemt_ce0, statemt_ce1,
        output statemt_we0, statemt_we1,
        output statemt_d0, statemt_d1,
        output word_address0, word_address1,
        output word_ce0, word_ce1
    );

    modport slave (
        output ap_start, ap_continue, n, mode,
        output statemt_q0, statemt_q1, word_q0, word_q1,
        input  ap_done, ap_idle, ap_ready, chk,
        input  statemt_address0, statemt_address1,
        input  statemt_ce0, statemt_ce1,
        input  statemt_we0, statemt_we1,
        input  statemt_d0, statemt_d1,
        input  word_address0, word_address1,
        input  word_ce0, word_ce1
    );
endinterface

// File: rtl/ark_addr_gen.sv
// Combinational state/key address generator for one row pair.
// Port 0 carries row 2p, port 1 carries row 2p+1.
module ark_addr_gen
    import ark_pkg::*;
#(
    parameter int NB         = 4,
    parameter int ROWS       = 4,
    parameter int ROW_STRIDE = 120,
    parameter int STATE_AW   = 5,
    parameter int WORD_AW    = 9,
    parameter int JW         = 2,
    parameter int PW         = 1
) (
    input  logic [JW-1:0]       j,
    input  logic [PW-1:0]       p,
    input  logic [4:0]          n,
    output logic [STATE_AW-1:0] state_addr0,
    output logic [STATE_AW-1:0] state_addr1,
    output logic [WORD_AW-1:0]  word_addr0,
    output logic [WORD_AW-1:0]  word_addr1
);
    logic [31:0] row0;
    logic [31:0] row1;
    logic [31:0] key_base;

    assign row0     = 32'({p, 1'b0});
    assign row1     = row0 + 32'd1;
    assign key_base = 32'(n) * NB + 32'(j);

    // Key addresses wrap at the RAM size by truncation.
    assign state_addr0 = STATE_AW'(32'(j) * ROWS + row0);
    assign state_addr1 = STATE_AW'(32'(j) * ROWS + row1);
    assign word_addr0  = WORD_AW'(row0 * ROW_STRIDE + key_base);
    assign word_addr1  = WORD_AW'(row1 * ROW_STRIDE + key_base);

endmodule

// File: rtl/add_round_key_nb.sv
// In-place AddRoundKey engine: XOR/copy/load of one round key into
// the state RAM, two rows per cycle, with a running write checksum.
module add_round_key_nb
    import ark_pkg::*;
#(
    parameter int NB         = 4,
    parameter int ROWS       = 4,
    parameter int DW         = 32,
    parameter int STATE_AW   = 5,
    parameter int WORD_AW    = 9,
    parameter int ROW_STRIDE = 120
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    add_round_key_nb_if.master bus
);
    localparam int NP = ROWS / 2;
    localparam int JW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(NB - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NP - 1);

    if (!rows_ok(ROWS)) begin : g_bad_rows
        $error("add_round_key_nb: ROWS must be even and >= 4");
    end

    ark_state_e          state;
    logic [JW-1:0]       j;
    logic [PW-1:0]       p;
    logic [PW-1:0]       cap_p;
    logic                cap_vld;
    logic [4:0]          n_q;
    logic [1:0]          mode_q;
    logic                ready_q;
    logic [DW-1:0]       chk_q;
    logic [DW-1:0]       col_buf [ROWS];
    logic [DW-1:0]       cap0;
    logic [DW-1:0]       cap1;
    logic [DW-1:0]       d0;
    logic [DW-1:0]       d1;
    logic [STATE_AW-1:0] sa0;
    logic [STATE_AW-1:0] sa1;
    logic [WORD_AW-1:0]  wa0;
    logic [WORD_AW-1:0]  wa1;
    logic                rd;
    logic                wr;
    logic [PW:0]         wi0;
    logic [PW:0]         wi1;
    logic [PW:0]         ci0;
    logic [PW:0]         ci1;

    ark_addr_gen #(
        .NB(NB), .ROWS(ROWS), .ROW_STRIDE(ROW_STRIDE),
        .STATE_AW(STATE_AW), .WORD_AW(WORD_AW),
        .JW(JW), .PW(PW)
    ) u_addr (
        .j(j), .p(p), .n(n_q),
        .state_addr0(sa0), .state_addr1(sa1),
        .word_addr0(wa0), .word_addr1(wa1)
    );

    assign rd  = (state == S_READ);
    assign wr  = (state == S_WRITE);
    assign wi0 = {p, 1'b0};
    assign wi1 = {p, 1'b1};
    assign ci0 = {cap_p, 1'b0};
    assign ci1 = {cap_p, 1'b1};
    assign d0  = col_buf[wi0];
    assign d1  = col_buf[wi1];

    always_comb begin
        cap0 = bus.statemt_q0 ^ bus.word_q0;
        cap1 = bus.statemt_q1 ^ bus.word_q1;
        unique case (1'b1)
            (mode_q == ARK_COPY): begin
                cap0 = bus.statemt_q0;
                cap1 = bus.statemt_q1;
            end
            (mode_q == ARK_LOAD): begin
                cap0 = bus.word_q0;
                cap1 = bus.word_q1;
            end
            default: ;
        endcase
    end

    assign bus.statemt_address0 = (rd | wr) ? sa0 : '0;
    assign bus.statemt_address1 = (rd | wr) ? sa1 : '0;
    assign bus.statemt_ce0      = rd | wr;
    assign bus.statemt_ce1      = rd | wr;
    assign bus.statemt_we0      = wr;
    assign bus.statemt_we1      = wr;
    assign bus.statemt_d0       = wr ? d0 : '0;
    assign bus.statemt_d1       = wr ? d1 : '0;
    assign bus.word_address0    = rd ? wa0 : '0;
    assign bus.word_address1    = rd ? wa1 : '0;
    assign bus.word_ce0         = rd;
    assign bus.word_ce1         = rd;
    assign bus.ap_done          = (state == S_DONE);
    assign bus.ap_ready         = ready_q;
    assign bus.ap_idle          = (state == S_IDLE) & ~bus.ap_start;
    assign bus.chk              = chk_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= S_IDLE;
            j       <= '0;
            p       <= '0;
            cap_p   <= '0;
            cap_vld <= 1'b0;
            n_q     <= '0;
            mode_q  <= ARK_XOR;
            ready_q <= 1'b0;
            chk_q   <= '0;
            for (int i = 0; i < ROWS; i++) col_buf[i] <= '0;
        end else begin
            ready_q <= 1'b0;
            // RAM data returns one cycle after the READ that fetched it.
            cap_vld <= rd;
            cap_p   <= p;
            if (cap_vld) begin
                col_buf[ci0] <= cap0;
                col_buf[ci1] <= cap1;
            end
            unique case (state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        n_q    <= bus.n;
                        mode_q <= bus.mode;
                        j      <= '0;
                        p      <= '0;
                        chk_q  <= '0;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    if (p == P_LAST) begin
                        p     <= '0;
                        state <= S_WRITE;
                    end else begin
                        p <= p + 1'b1;
                    end
                end
                S_WRITE: begin
                    chk_q <= chk_q ^ d0 ^ d1;
                    if (p == P_LAST) begin
                        p <= '0;
                        if (j == J_LAST) begin
                            state   <= S_DONE;
                            ready_q <= 1'b1;
                        end else begin
                            j     <= j + 1'b1;
                            state <= S_READ;
                        end
                    end else begin
                        p <= p + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.ap_continue) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_round_key_nb.sv
// Directed bench for add_round_key_nb: default 4x4 instance and an
// NB=8/ROWS=6 instance, each wired to behavioural 1-cycle RAMs.
module tb_add_round_key_nb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    logic corrupt = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    add_round_key_nb_if #(.DW(32), .STATE_AW(5), .WORD_AW(9)) bus_a ();
    add_round_key_nb_if #(.DW(32), .STATE_AW(6), .WORD_AW(9)) bus_b ();

    add_round_key_nb dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_a)
    );

    add_round_key_nb #(
        .NB(8), .ROWS(6), .DW(32), .STATE_AW(6),
        .WORD_AW(9), .ROW_STRIDE(200)
    ) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_b)
    );

    logic [31:0] st_a [32];
    logic [31:0] st_b [64];
    logic [31:0] exp_m [48];
    logic [31:0] snap [16];
    logic [31:0] sq0_a, sq1_a, wq0_a, wq1_a;
    logic [31:0] sq0_b, sq1_b, wq0_b, wq1_b;

    function automatic logic [31:0] wa(input int a);
        return 32'(a) * 32'h01010101;
    endfunction

    function automatic logic [31:0] wb(input int a);
        return (32'(a) * 32'h00010001) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_f(input logic [1:0] m,
                                          input logic [31:0] s,
                                          input logic [31:0] w);
        if (m == 2'd1) return s;
        if (m == 2'd2) return w;
        return s ^ w;
    endfunction

    // Read-first dual-port RAM models, 1-cycle latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) st_a[i] <= 32'(i);
            for (int i = 0; i < 64; i++)
                st_b[i] <= (32'(i) * 32'h11) ^ 32'hA5000000;
        end else begin
            if (bus_a.statemt_ce0) begin
                sq0_a <= st_a[bus_a.statemt_address0];
                if (bus_a.statemt_we0)
                    st_a[bus_a.statemt_address0] <= bus_a.statemt_d0;
            end
            if (bus_a.statemt_ce1) begin
                sq1_a <= st_a[bus_a.statemt_address1];
                if (bus_a.statemt_we1)
                    st_a[bus_a.statemt_address1] <= bus_a.statemt_d1;
            end
            if (bus_b.statemt_ce0) begin
                sq0_b <= st_b[bus_b.statemt_address0];
                if (bus_b.statemt_we0)
                    st_b[bus_b.statemt_address0] <= bus_b.statemt_d0;
            end
            if (bus_b.statemt_ce1) begin
                sq1_b <= st_b[bus_b.statemt_address1];
                if (bus_b.statemt_we1)
                    st_b[bus_b.statemt_address1] <= bus_b.statemt_d1;
            end
        end
        if (bus_a.word_ce0) wq0_a <= wa(int'(bus_a.word_address0));
        if (bus_a.word_ce1) wq1_a <= wa(int'(bus_a.word_address1));
        if (bus_b.word_ce0) wq0_b <= wb(int'(bus_b.word_address0));
        if (bus_b.word_ce1) wq1_b <= wb(int'(bus_b.word_address1));
    end

    assign bus_a.statemt_q0 = sq0_a ^ (corrupt ? 32'hDEADBEEF : 32'h0);
    assign bus_a.statemt_q1 = sq1_a ^ (corrupt ? 32'h0BADF00D : 32'h0);
    assign bus_a.word_q0    = wq0_a;
    assign bus_a.word_q1    = wq1_a;
    assign bus_b.statemt_q0 = sq0_b;
    assign bus_b.statemt_q1 = sq1_b;
    assign bus_b.word_q0    = wq0_b;
    assign bus_b.word_q1    = wq1_b;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit sel, input logic [1:0] m,
                         input int nn, output logic [31:0] ce);
        int nb;
        int rows;
        int stride;
        int i;
        int ka;
        logic [31:0] s;
        logic [31:0] w;
        nb = sel ? 8 : 4;
        rows = sel ? 6 : 4;
        stride = sel ? 200 : 120;
        ce = '0;
        for (int jj = 0; jj < nb; jj++) begin
            for (int r = 0; r < rows; r++) begin
                i = jj * rows + r;
                ka = (r * stride + nn * nb + jj) % 512;
                s = sel ? st_b[i] : st_a[i];
                w = sel ? wb(ka) : wa(ka);
                exp_m[i] = ref_f(m, s, w);
                ce ^= exp_m[i];
            end
        end
    endtask

    task automatic cmp_mem(input bit sel, input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < (sel ? 48 : 16); i++)
            if ((sel ? st_b[i] : st_a[i]) !== exp_m[i]) mism++;
        check(tag, 64'(mism), 64'd0);
    endtask

    task automatic go(input bit sel, input logic [1:0] m,
                      input logic [4:0] nn);
        if (sel) begin
            bus_b.mode = m; bus_b.n = nn; bus_b.ap_start = 1'b1;
        end else begin
            bus_a.mode = m; bus_a.n = nn; bus_a.ap_start = 1'b1;
        end
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_done(input bit sel, output int cyc,
                             output int wrs);
        tick;
        if (sel) bus_b.ap_start = 1'b0;
        else bus_a.ap_start = 1'b0;
        cyc = 1;
        wrs = 0;
        while (!(sel ? bus_b.ap_done : bus_a.ap_done) && cyc < 400) begin
            if (sel)
                wrs += int'(bus_b.statemt_we0) + int'(bus_b.statemt_we1);
            else
                wrs += int'(bus_a.statemt_we0) + int'(bus_a.statemt_we1);
            tick;
            cyc++;
        end
    endtask

    task automatic release_done(input bit sel);
        if (sel) bus_b.ap_continue = 1'b1;
        else bus_a.ap_continue = 1'b1;
        tick;
        bus_a.ap_continue = 1'b0;
        bus_b.ap_continue = 1'b0;
    endtask

    initial begin
        logic [31:0] ce;
        int cyc;
        int wrs;
        int ok;
        int rdy;
        int mism;
        bus_a.ap_start = 0; bus_a.ap_continue = 0;
        bus_a.mode = 0; bus_a.n = 0;
        bus_b.ap_start = 0; bus_b.ap_continue = 0;
        bus_b.mode = 0; bus_b.n = 0;
        tick;
        tick;
        check("rst_ctl_a",
              {bus_a.ap_done, bus_a.ap_ready, bus_a.ap_idle}, 3'b001);
        check("rst_en_a",
              {bus_a.statemt_ce0, bus_a.statemt_ce1, bus_a.statemt_we0,
               bus_a.statemt_we1, bus_a.word_ce0, bus_a.word_ce1}, 6'b0);
        check("rst_bus_a",
              {bus_a.statemt_address0, bus_a.statemt_address1,
               bus_a.word_address0, bus_a.word_address1,
               bus_a.statemt_d0}, 64'd0);
        check("rst_chk_a", bus_a.chk, 32'd0);
        check("rst_ctl_b",
              {bus_b.ap_done, bus_b.ap_ready, bus_b.ap_idle}, 3'b001);
        preload = 1'b0;
        rst_n = 1'b1;
        tick;

        model(0, 2'd0, 0, ce);
        go(0, 2'd0, 5'd0);
        wait_done(0, cyc, wrs);
        check("m0_cycles", 64'(cyc), 64'd17);
        check("m0_ready", bus_a.ap_ready, 1'b1);
        check("m0_chk", bus_a.chk, ce);
        check("m0_writes", 64'(wrs), 64'd16);
        cmp_mem(0, "m0_state");
        check("m0_spot5", st_a[5], 32'h7979797C);
        check("m0_spot15", st_a[15], 32'h6C6C6C64);

        ok = 1;
        rdy = int'(bus_a.ap_ready);
        for (int k = 0; k < 5; k++) begin
            tick;
            if (!bus_a.ap_done) ok = 0;
            rdy += int'(bus_a.ap_ready);
        end
        check("hold_done", 64'(ok), 64'd1);
        check("ready_pulses", 64'(rdy), 64'd1);

        model(0, 2'd2, 3, ce);
        corrupt = 1'b1;
        bus_a.mode = 2'd2;
        bus_a.n = 5'd3;
        bus_a.ap_continue = 1'b1;
        bus_a.ap_start = 1'b1;
        tick;
        bus_a.ap_continue = 1'b0;
        check("chain_idle",
              {bus_a.ap_done, bus_a.statemt_ce0, bus_a.ap_idle}, 3'b000);
        wait_done(0, cyc, wrs);
        check("m2_cycles", 64'(cyc), 64'd17);
        check("m2_chk", bus_a.chk, ce);
        cmp_mem(0, "m2_state");
        check("m2_spot1", st_a[1], 32'h84848484);
        corrupt = 1'b0;
        release_done(0);

        model(0, 2'd1, 7, ce);
        go(0, 2'd1, 5'd7);
        wait_done(0, cyc, wrs);
        check("m1_writes", 64'(wrs), 64'd16);
        check("m1_chk", bus_a.chk, ce);
        cmp_mem(0, "m1_state");
        release_done(0);

        model(0, 2'd3, 2, ce);
        go(0, 2'd3, 5'd2);
        wait_done(0, cyc, wrs);
        check("m3_chk", bus_a.chk, ce);
        cmp_mem(0, "m3_state");
        release_done(0);

        for (int i = 0; i < 16; i++) snap[i] = st_a[i];
        model(0, 2'd0, 1, ce);
        go(0, 2'd0, 5'd1);
        tick;
        bus_a.ap_start = 1'b0;
        for (int k = 2; k <= 11; k++) tick;
        check("rst_mid_we", bus_a.statemt_we0, 1'b1);
        check("rst_mid_addr", bus_a.statemt_address0, 5'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_en",
              {bus_a.statemt_ce0, bus_a.statemt_ce1, bus_a.statemt_we0,
               bus_a.statemt_we1, bus_a.word_ce0, bus_a.word_ce1}, 6'b0);
        tick;
        rst_n = 1'b1;
        tick;
        check("rst_after",
              {bus_a.ap_idle, bus_a.ap_done, bus_a.ap_ready}, 3'b100);
        mism = 0;
        for (int i = 12; i < 16; i++) if (st_a[i] !== snap[i]) mism++;
        check("rst_col3_kept", 64'(mism), 64'd0);
        mism = 0;
        for (int i = 0; i < 8; i++) if (st_a[i] !== exp_m[i]) mism++;
        check("rst_col01_done", 64'(mism), 64'd0);

        model(1, 2'd0, 31, ce);
        go(1, 2'd0, 5'd31);
        wait_done(1, cyc, wrs);
        check("b_cycles", 64'(cyc), 64'd49);
        check("b_writes", 64'(wrs), 64'd48);
        check("b_chk", bus_b.chk, ce);
        cmp_mem(1, "b_state");
        check("b_spot5_wrap", st_b[5], 32'hFFBA00B5);
        release_done(1);
        check("b_back_idle", bus_b.ap_idle, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_round_key_nb.md
# add_round_key_nb

Parametrised AddRoundKey engine for the AES decrypt datapath. It XORs one round key from the expanded-key memory into the state memory, in place. Column count, row count, data width and key-memory row stride are all configurable. Beyond plain key addition it has three operating modes, a registered XOR checksum of everything it writes, and an `ap_continue` done-hold handshake so an upstream round controller can chain invocations. It sits between the round controller and the `statemt`/`word` dual-port RAMs, in the same slot as the fixed 4×4 round-key adder.

## Interface
Parameters:
- `NB`, 4: number of state columns.
- `ROWS`, 4: rows per column. Must be even and ≥4; elaboration fails otherwise.
- `DW`, 32: RAM data width.
- `STATE_AW`, 5: `statemt` address width.
- `WORD_AW`, 9: `word` address width.
- `ROW_STRIDE`, 120: word-address distance between key rows.

Ports:
- `ap_clk` in 1: clock. All logic is rising-edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `ap_start` in 1: start request.
- `ap_continue` in 1: acknowledges done.
- `ap_done`, `ap_idle`, `ap_ready` out 1 each: control handshake.
- `n` in 5: round index.
- `mode` in 2: operating mode. 0 = XOR, 1 = copy (state unchanged, rewritten), 2 = load (state := key), 3 = reserved, behaves as 0.
- `statemt_address0/1` out STATE_AW: state RAM addresses.
- `statemt_ce0/1`, `statemt_we0/1` out 1: state RAM enables.
- `statemt_d0/1` out DW: state RAM write data.
- `statemt_q0/1` in DW: state RAM read data.
- `word_address0/1` out WORD_AW: key RAM addresses.
- `word_ce0/1` out 1: key RAM enables.
- `word_q0/1` in DW: key RAM read data.
- `chk` out DW: XOR of all words written in the last run. Valid while `ap_done`=1.

## Operation
- States are IDLE, READ, WRITE and DONE.
- Counters:
  - `j` counts columns, 0..NB-1.
  - `p` counts pairs, 0..ROWS/2-1.
- IDLE:
  - `ap_idle` = !`ap_start`.
  - On `ap_start`=1, latch `n` and `mode`, clear `j`, `p` and `chk`, then go to READ.
- Addressing for row r of column j:
  - State address = j·ROWS + r.
  - Key address = r·ROW_STRIDE + n·NB + j, computed modulo 2^WORD_AW.
  - Port 0 carries row 2p; port 1 carries row 2p+1.
- READ, one cycle per pair:
  - Assert `statemt_ce0/1` and `word_ce0/1` with the pair-p addresses.
  - At p = ROWS/2-1, go to WRITE with p cleared.
- Capture: one cycle after each read, store the result for port k into a ROWS-deep column buffer. The result depends on mode:
  - XOR: q_state ^ q_word.
  - Copy: q_state.
  - Load: q_word.
- The capture of the last pair happens in WRITE cycle 0.
- WRITE, one cycle per pair:
  - Assert `statemt_ce`/`we` on both ports with the pair-p addresses and the buffered data.
  - `word_ce` is 0.
  - Update `chk ^= d0 ^ d1`.
  - At the last pair: if j = NB-1, go to DONE; otherwise increment j and go to READ.
- DONE:
  - `ap_done`=1 and `ap_ready`=1 for the first DONE cycle only.
  - `ap_done` holds until `ap_continue`=1, then go to IDLE.
  - `ap_start` is ignored while in DONE.
- Simultaneous `ap_continue` and `ap_start` in DONE: go to IDLE. The new start is accepted on the following cycle.

## Timing
- RAM read latency is 1 cycle.
- Each column takes ROWS cycles: ROWS/2 READ + ROWS/2 WRITE.
- Run length from the `ap_start` accept edge to first `ap_done`=1 is NB·ROWS + 1 cycles. Default configuration: 17.
- A write of pair m never uses data captured in the same cycle. This is guaranteed by ROWS ≥ 4.
- Reset values:
  - State is IDLE.
  - `ap_done`=0, `ap_ready`=0, `ap_idle`=!`ap_start`.
  - All ce/we = 0.
  - Addresses and d = 0.
  - `chk`=0.
- Reset asserted mid-run aborts immediately. Partially written state is not restored.
- In IDLE, all RAM enables are 0.

## Structure
- Package `ark_pkg` holds:
  - The FSM state enum.
  - Mode constants `ARK_XOR`, `ARK_COPY`, `ARK_LOAD`.
  - The ROWS ≥ 4 / even legality check function.
- Sub-module `ark_addr_gen` is purely combinational:
  - Inputs: j, p, latched n.
  - Outputs: both state addresses and both key addresses.
  - Instanced once.

## Test plan
- Default parameters, mode 0, n=0, state[i]=i, word[a]=a·0x01010101:
  - Every state[j·4+r] becomes i ^ word[r·120+j].
  - `ap_done` at cycle 17.
  - `chk` = XOR of all 16 results.
- Mode 2, n=3:
  - state[j·4+r] = word[r·120+12+j].
  - No state read value is used.
- Mode 1:
  - State is unchanged after the run.
  - `chk` = XOR of state[0..15].
  - 16 write strobes are observed.
- Back-to-back chaining:
  - Hold `ap_continue`=0 for 5 cycles after done: `ap_done` stays 1 and `ap_ready` pulses exactly once.
  - Then assert `ap_continue` and `ap_start` together: the new run is accepted one cycle after IDLE.
- `ap_rst_n` low during WRITE of column 2:
  - All enables drop to 0 asynchronously.
  - After release: `ap_idle`=1, and columns 3 onward are untouched.
- NB=8, ROWS=6, ROW_STRIDE=200, n=31:
  - Key addresses wrap modulo 512.
  - Run takes 49 cycles.
  - Results match the reference model.
